// File: rtl/vga_timing_if.sv
// vga_timing_if
//   Raster timing bundle produced by vga_timing and consumed by the overlay
//   stage and the sync path to the connector. All signals are registered in
//   the producer and aligned to the same pixel.
//
//   hcount_out     : horizontal pixel index (11 bits)
//   vcount_out     : vertical line index (10 bits)
//   hblnk_out      : horizontal blanking
//   vblnk_out      : vertical blanking
//   hsync_out      : horizontal sync, positive polarity
//   vsync_out      : vertical sync, positive polarity
//   frame_tick_out : one-clock pulse on the (last,last)->(0,0) wrap; present
//                    only when VGA_FRAME_TICK_EN is defined
//
//   Modports: master = timing generator side, slave = consumer side.
interface vga_timing_if;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic        hsync_out;
  logic        vsync_out;
`ifdef VGA_FRAME_TICK_EN
  logic        frame_tick_out;

  modport master (
    output hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out, frame_tick_out
  );
  modport slave (
    input  hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out, frame_tick_out
  );
`else
  modport master (
    output hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out
  );
  modport slave (
    input  hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out
  );
`endif
endinterface : vga_timing_if

// File: rtl/vga_timing.sv
// vga_timing
//   Free-running VGA raster timing generator (defaults: 800x600@60, 40 MHz
//   pixel rate). Produces pixel/line counters plus blanking and sync flags.
//   The flags are decoded from the next-state counter values, so counts and
//   flags for a given pixel leave this block on the same clock edge.
//
//   Ports:
//     clk    : pixel clock, rising-edge active
//     rst    : asynchronous reset, active low (0 = reset)
//     pix_en : advance enable; every register holds when it is 0
//     vga    : vga_timing_if.master carrying counts, blanks, syncs
//
//   Optional feature macro: VGA_FRAME_TICK_EN adds a registered
//   frame_tick_out pulse on the raster wrap from the last pixel of the last
//   line back to (0,0).
//
//   H_ACTIVE+H_FP+H_SYNC+H_BP must not exceed 2048 and the vertical sum must
//   not exceed 1024, since compares are done at the 11/10-bit counter widths.
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_en,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_BLNK_START = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        h_wrap;

  assign h_wrap = (h_q == H_LAST);

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    h_d     = h_q;
    v_d     = v_q;
    hblnk_d = hblnk_q;
    vblnk_d = vblnk_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;

    if (pix_en) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
      end

      // Decode from the next-state counts so flags and counts register
      // together on the same edge.
      hblnk_d = (h_d >= H_BLNK_START);
      hsync_d = (h_d >= H_SYNC_START) && (h_d < H_SYNC_END);
      vblnk_d = (v_d >= V_BLNK_START);
      vsync_d = (v_d >= V_SYNC_START) && (v_d < V_SYNC_END);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q     <= '0;
      v_q     <= '0;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values that
      // existed before this edge, independent of statement order.
      h_q     <= h_d;
      v_q     <= v_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga.hcount_out = h_q;
  assign vga.vcount_out = v_q;
  assign vga.hblnk_out  = hblnk_q;
  assign vga.vblnk_out  = vblnk_q;
  assign vga.hsync_out  = hsync_q;
  assign vga.vsync_out  = vsync_q;

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  // High only for the edge that wraps the whole raster; any other cycle,
  // enabled or not, clears it.
  assign frame_tick_d = pix_en && h_wrap && (v_q == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_tick_q <= 1'b0;
    else      frame_tick_q <= frame_tick_d;
  end

  assign vga.frame_tick_out = frame_tick_q;
`endif

endmodule : vga_timing

// File: doc/vga_timing.md
# vga_timing

Free-running VGA raster timing generator for the 800x600@60 Hz mode (40 MHz pixel rate). It produces the horizontal/vertical pixel counters, blanking and sync signals. It is the first stage of the video pipeline: its outputs feed the menu image overlay stage (count, blank and background inputs) and the sync path to the connector. All outputs are registered and mutually aligned, so downstream stages see count, blank and sync for the same pixel in the same cycle.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)

Derived values: H_TOTAL = 1056 and V_TOTAL = 628 with defaults.

Ports:
- clk  in  1  pixel-domain clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- pix_en  in  1  pixel advance enable; counters move only on cycles where it is 1
- hcount_out  out  11  horizontal pixel index, 0..H_TOTAL-1
- vcount_out  out  10  vertical line index, 0..V_TOTAL-1
- hblnk_out  out  1  1 while hcount_out >= H_ACTIVE
- vblnk_out  out  1  1 while vcount_out >= V_ACTIVE
- hsync_out  out  1  1 while H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (positive polarity)
- vsync_out  out  1  1 while V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (positive polarity)
- frame_tick_out  out  1  present only with VGA_FRAME_TICK_EN; see Configuration

## Operation
- Two counters form a raster state: h (line position) and v (frame position).
- On a pix_en=1 cycle:
  - If h != H_TOTAL-1: h increments.
  - Otherwise h wraps to 0 and v advances. v increments, or wraps to 0 when v == V_TOTAL-1.
- On a pix_en=0 cycle, all registers hold, including blank and sync.
- Blank and sync flags are decoded from the next-state counter values and registered in the same edge as the counters. There is never a one-cycle skew between the counts and the flags.
- Counter arithmetic is unsigned. Compare widths are 11 bits horizontal and 10 bits vertical. Parameter sums must fit these widths (H_TOTAL <= 2048, V_TOTAL <= 1024).
- Reset (rst=0), at any time including mid-line or mid-sync:
  - All outputs are 0 immediately (asynchronous): hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, hsync_out=0, vsync_out=0, frame_tick_out=0.
  - The raster restarts from pixel (0,0).
  - The first advance occurs on the first rising edge with rst=1 and pix_en=1.

## Timing
- Latency: hcount_out changes exactly one edge after a pix_en=1 sample. Flags change on that same edge.
- Line period: H_TOTAL enabled cycles. Frame period: H_TOTAL*V_TOTAL enabled cycles (663168 with defaults).
- hblnk_out rises on the edge where hcount_out becomes H_ACTIVE. It falls on the edge where hcount_out wraps to 0.
- vblnk_out, vsync_out and vcount_out change only on the edge where hcount_out wraps to 0.
- Simultaneous h wrap and v wrap (h=H_TOTAL-1, v=V_TOTAL-1, pix_en=1): both counters become 0 on the same edge. vblnk_out and vsync_out reflect line 0.
- pix_en may toggle arbitrarily. Outputs stay stable through any run of pix_en=0 cycles.

## Configuration
- Macro: VGA_FRAME_TICK_EN.
- When defined:
  - frame_tick_out exists as a registered output.
  - It is 1 for exactly one clock, on the edge where the raster wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - It clears on the next clock regardless of pix_en.
  - It is 0 on reset and never asserts on reset release.
- When undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset release, pix_en=1 constantly:
  - hcount_out steps 0,1,…,1055,0.
  - vcount_out goes 0→1 exactly at the first hcount wrap (cycle 1056).
- Horizontal decode over one line:
  - hblnk_out=1 exactly for hcount_out 800..1055.
  - hsync_out=1 exactly for hcount_out 840..967 (128 cycles).
- Vertical decode over one frame:
  - vblnk_out=1 for lines 600..627.
  - vsync_out=1 for lines 601..604.
  - Frame repeats after 663168 cycles, with (0,0) seen twice exactly that far apart.
- pix_en=1 every other cycle:
  - Line period becomes 2112 clocks.
  - Outputs unchanged during every pix_en=0 cycle.
- rst driven low asynchronously (between edges) at hcount_out=900, vcount_out=602:
  - All outputs 0 before the next edge.
  - After release, the raster restarts at (0,0).
- With VGA_FRAME_TICK_EN, pix_en=1:
  - frame_tick_out pulses once, 1 clock wide, at cycle 663168 after reset release.
  - No pulse at release itself.
